// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: opcodes, flag bundle, widths.
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        LU_AND,
        LU_OR,
        LU_NAND,
        LU_NOR,
        LU_NOTA,
        LU_NOTB,
        LU_XOR,
        LU_XNOR
    } lu_op_e;

    typedef struct packed {
        logic za;
        logic zb;
        logic eq;
        logic gt;
        logic lt;
    } lu_flags_t;

    localparam int LU_FLAGS_W = $bits(lu_flags_t);

endpackage

// File: rtl/lu_reg_slice.sv
// Generic valid/ready register stage; payload only loads on a valid transfer.
module lu_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Stage advances when empty or when its content leaves this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with compare flags and tag sideband.
// Optional signed compare mode: define LU_SIGNED_CMP_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef LU_SIGNED_CMP_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_res,
    output logic               out_za,
    output logic               out_zb,
    output logic               out_eq,
    output logic               out_gt,
    output logic               out_lt,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int S1_W = 2*WIDTH + LU_OP_W + TAG_W + 1;
    localparam int S2_W = WIDTH + LU_FLAGS_W + TAG_W;

    logic sgn;
`ifdef LU_SIGNED_CMP_EN
    assign sgn = in_signed;
`else
    assign sgn = 1'b0;
`endif

    logic            s1_valid;
    logic            s2_ready;
    logic [S1_W-1:0] s1_q;

    lu_reg_slice #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_a, in_b, in_op, in_tag, sgn}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [LU_OP_W-1:0] op_bits;
    logic [TAG_W-1:0]   tag;
    logic               sgn_q;
    lu_op_e             op;
    logic [WIDTH-1:0]   res;
    lu_flags_t          fl;

    assign {a, b, op_bits, tag, sgn_q} = s1_q;
    assign op = lu_op_e'(op_bits);

    always_comb begin
        res = '0;
        case (op)
            LU_AND:  res = a & b;
            LU_OR:   res = a | b;
            LU_NAND: res = ~(a & b);
            LU_NOR:  res = ~(a | b);
            LU_NOTA: res = ~a;
            LU_NOTB: res = ~b;
            LU_XOR:  res = a ^ b;
            LU_XNOR: res = ~(a ^ b);
            default: res = '0;
        endcase
    end

    // Flags depend on operands only; sign mode affects ordering, not equality.
    always_comb begin
        fl    = '0;
        fl.za = (a == '0);
        fl.zb = (b == '0);
        fl.eq = (a == b);
        if (sgn_q) begin
            fl.gt = $signed(a) > $signed(b);
            fl.lt = $signed(a) < $signed(b);
        end else begin
            fl.gt = a > b;
            fl.lt = a < b;
        end
    end

    logic [S2_W-1:0]  s2_q;
    logic [WIDTH-1:0] res_q;
    lu_flags_t        fl_q;

    lu_reg_slice #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   ({res, fl, tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign {res_q, fl_q, out_tag} = s2_q;
    assign out_res = {{WIDTH{1'b0}}, res_q};
    assign out_za  = fl_q.za;
    assign out_zb  = fl_q.zb;
    assign out_eq  = fl_q.eq;
    assign out_gt  = fl_q.gt;
    assign out_lt  = fl_q.lt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized + directed bench for logic_unit_pipe against a queue-based model.
module tb_logic_unit_pipe;

    localparam int W  = 16;
    localparam int TW = 4;
`ifdef LU_SIGNED_CMP_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] out_res;
    logic          out_za, out_zb, out_eq, out_gt, out_lt;
    logic [TW-1:0] out_tag;

    logic [4:0] flags;
    logic [2*W+5+TW-1:0] outs;
    assign flags = {out_za, out_zb, out_eq, out_gt, out_lt};
    assign outs  = {out_valid, out_res, flags, out_tag};

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
`ifdef LU_SIGNED_CMP_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_za    (out_za),
        .out_zb    (out_zb),
        .out_eq    (out_eq),
        .out_gt    (out_gt),
        .out_lt    (out_lt),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [2*W-1:0] res;
        logic [4:0]     fl;
        logic [TW-1:0]  tag;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lat = 0;
    bit   acc = 0;
    bit   stall = 0;
    logic [2*W+5+TW-1:0] snap = '0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic [2:0] op, logic [TW-1:0] t, bit s);
        exp_t e;
        logic [W-1:0] r;
        longint ia, ib;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~(a & b);
            3'd3: r = ~(a | b);
            3'd4: r = ~a;
            3'd5: r = ~b;
            3'd6: r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        ia = longint'(a);
        ib = longint'(b);
        if (s && a[W-1]) ia = ia - (longint'(1) << W);
        if (s && b[W-1]) ib = ib - (longint'(1) << W);
        e.res = {{W{1'b0}}, r};
        e.fl  = {a == '0, b == '0, ia == ib, ia > ib, ia < ib};
        e.tag = t;
        e.cyc = 0;
        return e;
    endfunction

    task automatic step(bit v, logic [W-1:0] a, logic [W-1:0] b,
                        logic [2:0] op, logic [TW-1:0] t, bit s, bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = t;
        in_signed = s;
        out_ready = ordy;
        #1;
        if (stall) check("hold", outs, snap);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious", 1, 0);
            end else begin
                e = q.pop_front();
                lat = cyc - e.cyc;
                check("res", out_res, e.res);
                check("flags", flags, e.fl);
                check("tag", out_tag, e.tag);
            end
        end
        acc = v && in_ready;
        if (acc) begin
            e = model(a, b, op, t, s && SGN_EN);
            e.cyc = cyc;
            q.push_back(e);
        end
        stall = out_valid && !out_ready;
        snap  = outs;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, 0, 1);
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_ovalid"}, out_valid, 0);
        check({tag, "_res"}, out_res, 0);
        check({tag, "_flags"}, flags, 0);
        check({tag, "_tag"}, out_tag, 0);
        check({tag, "_irdy"}, in_ready, 1);
    endtask

    int nacc;

    initial begin
        #12;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 16'hF0F0, 16'hFF00, 3'd0, 4'd1, 0, 1);
        idle(3);
        check("lat_first", lat, 2);

        for (int i = 0; i < 8; i++) step(1, 16'hAAAA, 16'h5555, 3'(i), 4'(i), 0, 1);
        idle(1);
        check("lat_b2b", lat, 2);
        idle(2);

        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 16'($urandom), 16'($urandom), 3'($urandom), 4'(i + 8), 0, 0);
            nacc += int'(acc);
        end
        check("stall_acc", nacc, 2);
        check("full_irdy", in_ready, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h1234, 16'h4321, 3'(i), 4'(i), 0, 1);
        idle(3);

        step(1, 16'h0000, 16'h0000, 3'd6, 4'd3, 0, 1);
        step(1, 16'h8000, 16'h0001, 3'd1, 4'd4, 0, 1);
        step(1, 16'h8000, 16'h0001, 3'd1, 4'd5, 1, 1);
        step(1, 16'hFFFF, 16'hFFFF, 3'd7, 4'd6, 0, 1);
        step(1, 16'hFFFF, 16'hFFFE, 3'd0, 4'd7, 0, 1);
        step(1, 16'h8000, 16'h7FFF, 3'd2, 4'd8, 1, 1);
        step(1, 16'h7FFF, 16'h8000, 3'd3, 4'd9, 1, 1);
        idle(3);

        for (int i = 0; i < 3; i++) step(1, 16'hBEEF, 16'hCAFE, 3'd6, 4'hF, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        q.delete();
        stall = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 16'h0F0F, 16'h00FF, 3'd6, 4'd2, 0, 1);
        check("post_rst_acc", acc, 1);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                 3'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
